// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general register file with a per-register pending scoreboard.
//
// Provides NR combinational read ports and NW synchronous write ports. A same-cycle write can be
// forwarded to matching read ports (BYPASS). Each register carries a pending bit that is set when
// an instruction naming it as destination issues, and cleared when it is written back. Decode
// stalls on rd_busy.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high; clears storage and pending bits, and forces outputs
//                  to zero while asserted
//   rd_addr   in   NR*AW  read addresses, port k at [k*AW +: AW]
//   rd_data   out  NR*DW  read data, combinational
//   rd_busy   out  NR     source register pending and not being written back this cycle
//   wr_en     in   NW     per-port write enable (higher port index wins on address collisions)
//   wr_addr   in   NW*AW  write addresses
//   wr_data   in   NW*DW  write data
//   iss_en    in   an instruction with a destination register issues this cycle
//   iss_addr  in   AW     destination of the issuing instruction
//   pend_vec  out  2**AW  current pending bits (debug/trace)

module regfile_mp #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NR       = 2,
  parameter int unsigned NW       = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NR*AW-1:0]     rd_addr,
  output logic [NR*DW-1:0]     rd_data,
  output logic [NR-1:0]        rd_busy,
  input  logic [NW-1:0]        wr_en,
  input  logic [NW*AW-1:0]     wr_addr,
  input  logic [NW*DW-1:0]     wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [(2**AW)-1:0]   pend_vec
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0]    mem_q [Depth];
  logic [DW-1:0]    mem_d [Depth];
  logic [Depth-1:0] pend_q;
  logic [Depth-1:0] pend_d;
  logic [NW-1:0]    wr_eff;
  logic             iss_eff;

  // A write to register 0 is dropped entirely when it is hardwired to zero, so it neither
  // updates storage, clears pending, nor bypasses.
  always_comb begin
    wr_eff = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      wr_eff[j] = wr_en[j] && !(ZERO_REG && (wr_addr[j*AW +: AW] == '0));
    end
    iss_eff = iss_en && !(ZERO_REG && (iss_addr == '0));
  end

  // Next state. Ports are applied in ascending order so the highest index overrides. Issue is
  // applied after writeback clears so a newer producer keeps ownership of the register.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    for (int unsigned j = 0; j < NW; j++) begin
      if (wr_eff[j]) begin
        mem_d[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
        pend_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_eff) begin
      pend_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < Depth; r++) begin
        mem_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int unsigned r = 0; r < Depth; r++) begin
        mem_q[r] <= mem_d[r];
      end
      pend_q <= pend_d;
    end
  end

  // Read ports. A bypass hit also masks busy: the value the consumer needs is on the bus now.
  always_comb begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rdat;
    logic          hit;
    logic          zero_hit;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      ra       = rd_addr[k*AW +: AW];
      rdat     = mem_q[ra];
      hit      = 1'b0;
      zero_hit = ZERO_REG && (ra == '0);
      if (BYPASS) begin
        for (int unsigned j = 0; j < NW; j++) begin
          if (wr_eff[j] && (wr_addr[j*AW +: AW] == ra)) begin
            rdat = wr_data[j*DW +: DW];
            hit  = 1'b1;
          end
        end
      end
      if (zero_hit) begin
        rdat = '0;
      end
      rd_data[k*DW +: DW] = reset ? '0 : rdat;
      rd_busy[k]          = !reset && pend_q[ra] && !hit && !zero_hit;
    end
  end

  assign pend_vec = reset ? '0 : pend_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data_b, rd_data_n;
  logic [NR-1:0]     rd_busy_b, rd_busy_n;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [DEPTH-1:0]  pend_vec_b, pend_vec_n;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural register contents and pending set.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_pend [DEPTH];

  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .pend_vec(pend_vec_b)
  );

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .pend_vec(pend_vec_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_eff(input int j);
    return wr_en[j] && (wr_addr[j*AW +: AW] != 0);
  endfunction

  // Latest effective write to addr this cycle (highest port wins); found=0 if none.
  function automatic logic [DW-1:0] m_fwd(input int addr, output bit found);
    logic [DW-1:0] v = '0;
    found = 1'b0;
    for (int j = 0; j < NW; j++) begin
      if (m_eff(j) && int'(wr_addr[j*AW +: AW]) == addr) begin
        v = wr_data[j*DW +: DW];
        found = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] m_read(input int addr, input bit byp);
    bit found;
    logic [DW-1:0] f;
    if (reset || addr == 0) return '0;
    f = m_fwd(addr, found);
    if (byp && found) return f;
    return m_regs[addr];
  endfunction

  function automatic bit m_busy(input int addr, input bit byp);
    bit found;
    logic [DW-1:0] f;
    if (reset || addr == 0) return 1'b0;
    f = m_fwd(addr, found);
    return m_pend[addr] && !(byp && found);
  endfunction

  function automatic logic [DEPTH-1:0] m_pvec();
    logic [DEPTH-1:0] v = '0;
    if (!reset) for (int r = 0; r < DEPTH; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic model_edge();
    bit found;
    logic [DW-1:0] f;
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        f = m_fwd(r, found);
        if (found) begin
          m_regs[r] = f;
          m_pend[r] = 1'b0;
        end
      end
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
  endtask

  task automatic check_all();
    int a;
    for (int k = 0; k < NR; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      chk($sformatf("byp_rd_data%0d@r%0d", k, a), 64'(rd_data_b[k*DW +: DW]), 64'(m_read(a, 1)));
      chk($sformatf("byp_rd_busy%0d@r%0d", k, a), 64'(rd_busy_b[k]), 64'(m_busy(a, 1)));
      chk($sformatf("nb_rd_data%0d@r%0d", k, a), 64'(rd_data_n[k*DW +: DW]), 64'(m_read(a, 0)));
      chk($sformatf("nb_rd_busy%0d@r%0d", k, a), 64'(rd_busy_n[k]), 64'(m_busy(a, 0)));
    end
    chk("byp_pend_vec", 64'(pend_vec_b), 64'(m_pvec()));
    chk("nb_pend_vec", 64'(pend_vec_n), 64'(m_pvec()));
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
    wr_en[j]            = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*DW +: DW] = d;
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    for (int r = 0; r < DEPTH; r++) begin
      m_regs[r] = 'x;
      m_pend[r] = 1'b0;
    end
    settle(); tick(); settle(); tick();
    reset = 1'b0;

    // Everything reads zero after reset.
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a);
      settle();
      chk("reset_rd0_zero", 64'(rd_data_b[31:0]), 64'h0);
      tick();
    end

    // r0 ignores writes.
    set_wr(0, 0, 32'hFFFF_FFFF); iss_en = 1'b1; iss_addr = '0; set_rd(0, 0);
    settle(); tick(); idle();
    settle();
    chk("r0_still_zero", 64'(rd_data_b[31:0]), 64'h0);
    chk("r0_not_pending", 64'(pend_vec_b[0]), 64'h0);
    tick();

    // Bypass vs. no-bypass on first write.
    set_wr(0, 5, 32'h1234_5678); set_rd(0, 5);
    settle();
    chk("bypass_r5", 64'(rd_data_b[63:32]), 64'h1234_5678);
    chk("nobypass_r5_old", 64'(rd_data_n[63:32]), 64'h0);
    tick(); idle();
    settle();
    chk("stored_r5", 64'(rd_data_n[63:32]), 64'h1234_5678);
    tick();

    // Two ports hit the same register: port 1 wins.
    set_wr(0, 7, 32'hAAAA_0000); set_wr(1, 7, 32'h0000_BBBB); set_rd(7, 5);
    settle();
    chk("prio_bypass_r7", 64'(rd_data_b[31:0]), 64'h0000_BBBB);
    tick(); idle();
    settle();
    chk("prio_stored_r7", 64'(rd_data_n[31:0]), 64'h0000_BBBB);
    tick();

    // Issue then writeback.
    iss_en = 1'b1; iss_addr = 5'd3; set_rd(3, 3);
    settle(); tick(); idle();
    settle();
    chk("iss_pend3", 64'(pend_vec_b[3]), 64'h1);
    chk("iss_busy3", 64'(rd_busy_b[0]), 64'h1);
    tick();
    set_wr(0, 3, 32'h55);
    settle();
    chk("wb_busy3_byp", 64'(rd_busy_b[0]), 64'h0);
    chk("wb_data3_byp", 64'(rd_data_b[31:0]), 64'h55);
    chk("wb_busy3_nb", 64'(rd_busy_n[0]), 64'h1);
    tick(); idle();
    settle();
    chk("wb_pend3_clr", 64'(pend_vec_b[3]), 64'h0);
    tick();

    // Issue and writeback of the same register in one cycle: set wins.
    iss_en = 1'b1; iss_addr = 5'd4; set_wr(0, 4, 32'h99); set_rd(4, 4);
    settle();
    chk("setwin_busy_now", 64'(rd_busy_b[0]), 64'h0);
    tick(); idle();
    settle();
    chk("setwin_data4", 64'(rd_data_b[31:0]), 64'h99);
    chk("setwin_pend4", 64'(pend_vec_b[4]), 64'h1);
    chk("setwin_busy4", 64'(rd_busy_b[0]), 64'h1);
    tick();

    // Reset mid-operation discards that edge's events.
    iss_en = 1'b1; iss_addr = 5'd9; set_wr(0, 10, 32'h1);
    settle(); tick(); idle();
    reset = 1'b1; set_wr(1, 11, 32'h2); iss_en = 1'b1; iss_addr = 5'd12; set_rd(10, 11);
    settle();
    chk("inreset_data0", 64'(rd_data_b[31:0]), 64'h0);
    chk("inreset_pvec", 64'(pend_vec_b), 64'h0);
    tick(); idle(); reset = 1'b0;
    settle();
    chk("post_reset_pvec", 64'(pend_vec_b), 64'h0);
    chk("post_reset_r10", 64'(rd_data_n[31:0]), 64'h0);
    chk("post_reset_r11", 64'(rd_data_n[63:32]), 64'h0);
    tick();

    // Random traffic; narrow address range often to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 59) == 0);
      for (int j = 0; j < NW; j++) begin
        wr_en[j]            = ($urandom_range(0, 2) != 0);
        wr_addr[j*AW +: AW] = AW'(narrow ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
        wr_data[j*DW +: DW] = $urandom;
      end
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = AW'(narrow ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
      for (int k = 0; k < NR; k++) begin
        rd_addr[k*AW +: AW] = AW'(narrow ? $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1));
      end
      settle();
      tick();
    end
    reset = 1'b0; idle();
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general register file for the pipelined CPU core, with per-register scoreboard.
- Provides NR combinational read ports and NW synchronous write ports.
- Write-to-read bypass removes the same-cycle W→D hazard.
- Each register has a pending bit, set at issue and cleared at writeback.
- Decode stalls on rd_busy instead of comparing pipeline-stage addresses.

Parameters:
- DW, 32: data width in bits.
- AW, 5: address width; depth = 2**AW registers.
- NR, 2: number of read ports.
- NW, 2: number of write ports; higher index has higher priority.
- ZERO_REG, 1: when 1, register 0 reads 0, ignores writes and is never pending.
- BYPASS, 1: when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  NR*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NR*DW  read data, combinational.
- rd_busy  out  NR  1 = source register pending and not being written back this cycle.
- wr_en  in  NW  per-port write enable.
- wr_addr  in  NW*AW  write addresses.
- wr_data  in  NW*DW  write data.
- iss_en  in  1  an instruction with a destination register issues this cycle.
- iss_addr  in  AW  destination of the issuing instruction.
- pend_vec  out  2**AW  current pending bits, for debug and trace.

Behaviour:
- Reset:
  - On a rising edge with reset=1, all registers become 0 and all pending bits become 0.
  - Write and issue inputs are ignored on that edge.
  - While reset=1, rd_data=0, rd_busy=0 and pend_vec=0 (forced combinationally).
- Effective write, port j: wr_en[j]=1 and not (ZERO_REG and wr_addr[j]==0).
- Write priority:
  - If several effective ports target the same address in one cycle, the highest index j wins.
  - The losing data is discarded.
- Storage: on the rising edge, each winning effective write updates its register; latency is 1 cycle.
- Read port k, combinational:
  - If ZERO_REG and rd_addr[k]==0: data is 0.
  - Else if BYPASS and some effective write targets rd_addr[k] this cycle: data is wr_data of the highest-priority such port.
  - Else: data is the stored value.
- BYPASS=0: reads return the stored value; new data is visible the cycle after the edge.
- Pending bits, per register r, evaluated at the rising edge:
  - set_r = iss_en and iss_addr==r, excluding r=0 when ZERO_REG.
  - clr_r = any effective write to r.
  - set_r=1 → pending 1; set wins over a simultaneous clear, because the newer producer owns the register.
  - Else clr_r=1 → pending 0.
  - Else the bit holds.
- A write to a non-pending register is legal; it updates data and leaves pending at 0.
- Issue does not alter register data.
- rd_busy[k] = pending[rd_addr[k]] and not (BYPASS and an effective write targets rd_addr[k] this cycle).
- rd_busy[k] is 0 for address 0 when ZERO_REG.
- With BYPASS=0, rd_busy also ignores the same-cycle write; it clears the cycle after writeback.
- No state machine beyond the storage and pending arrays. All outputs derive from state plus current inputs; there are no registered outputs.
- Reset asserted mid-operation discards all in-flight issue and writeback events of that edge.
- Width rules:
  - Addresses are compared over the full AW bits; no truncation.
  - Data is passed unmodified; there is no sign handling.

Test Plan:
- Reset, then read all registers on both ports → every rd_data=0, pend_vec=0. Write port0 r0=0xFFFFFFFF → r0 still reads 0 and is never pending.
- Write port0 r5=0x12345678, same cycle read port1 r5 → rd_data1=0x12345678 via bypass. Next cycle stored r5=0x12345678. With BYPASS=0, the same cycle returns old value 0.
- Port0 and port1 both write r7 (0xAAAA0000, 0x0000BBBB) → readback r7=0x0000BBBB; a bypass read of r7 in that cycle also returns 0x0000BBBB.
- iss_en, iss_addr=3 → next cycle pend_vec[3]=1 and read of r3 gives rd_busy=1. Write r3=0x55 → rd_busy=0 that cycle with data 0x55. The following cycle pending[3]=0.
- Same cycle: iss_en to r4 and write r4=0x99 → r4=0x99 and pending[4]=1 afterwards (set wins); rd_busy for r4 is 0 in that cycle only.
- Issue r9 and write r10=0x1, then assert reset for 1 cycle with simultaneous write r11=0x2 and iss_en r12 → after the edge all registers 0, pend_vec=0, r11=0, r12 not pending.
